ram_port_arbiter: RTL
=====================

# ram_port_arbiter

Arbitrates the single port of the 128x8 data RAM between the CPU datapath (requester 0, high priority) and an auxiliary master such as a debug or DMA port (requester 1). It performs at most one RAM access per clock and guarantees the auxiliary master bounded waiting through a starvation counter. It also supports short locked auxiliary bursts. It sits between the CPU/aux masters and `single_port_ram_128x8`, driving that RAM's `data`, `addr` and `en` pins and consuming its `q`.

## Interface
- `ADDR_W`, 7: RAM address width.
- `DATA_W`, 8: RAM data width.
- `AUX_MAX_WAIT`, 4: cycles the aux requester may be denied before it is force-granted. Range 1..15.
- `AUX_MAX_BURST`, 8: maximum consecutive locked aux grants. Range 1..15.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `cpu_req`, `cpu_we` in 1: CPU access request and write-enable.
- `cpu_addr` in ADDR_W; `cpu_wdata` in DATA_W.
- `cpu_gnt` out 1: CPU access performed this cycle (combinational).
- `cpu_rdata` out DATA_W; `cpu_rvalid` out 1: registered read data and a 1-cycle valid pulse.
- `aux_req`, `aux_we`, `aux_lock` in 1: aux request, write-enable and burst lock.
- `aux_addr` in ADDR_W; `aux_wdata` in DATA_W.
- `aux_gnt` out 1; `aux_rdata` out DATA_W; `aux_rvalid` out 1: same meanings as the CPU outputs.
- `ram_addr` out ADDR_W; `ram_data` out DATA_W; `ram_en` out 1: RAM drive (`ram_en` = write strobe).
- `ram_q` in DATA_W: RAM read data, valid combinationally for the currently driven `ram_addr`.
- `aux_starved` out 1: high while `wait_cnt == AUX_MAX_WAIT`.

## Operation
- **States:**
  - `CPU_PRI` is the reset state.
  - `AUX_BURST`.
- **Grant in CPU_PRI:**
  - `aux_gnt = aux_req & (~cpu_req | wait_cnt == AUX_MAX_WAIT)`.
  - `cpu_gnt = cpu_req & ~aux_gnt`.
- **Grant in AUX_BURST:**
  - `aux_gnt = aux_req`.
  - `cpu_gnt = 0`.
- **Reset:** both grants are forced to 0 while `reset` is high, in every state.
- **Exclusivity:** `cpu_gnt` and `aux_gnt` are never high together.
- **RAM mux:**
  - The granted requester's addr/wdata drive `ram_addr`/`ram_data`.
  - `ram_en` = granted `we`.
  - With no grant: `ram_addr = 0`, `ram_data = 0`, `ram_en = 0`.
- **Reads:**
  - A granted access with `we = 0` registers `ram_q` into that requester's `rdata`.
  - That requester's `rvalid` pulses for the following cycle.
  - `rdata` holds its value until the next read by the same requester.
- **Writes:** produce no `rvalid`.
- **`wait_cnt`** (4 bits), updated each cycle:
  - Cleared when `aux_gnt` is high or `aux_req` is low.
  - Otherwise incremented, saturating at `AUX_MAX_WAIT`.
- **Burst entry:**
  - Condition: in CPU_PRI, `aux_gnt & aux_lock`.
  - Action: go to AUX_BURST and set `burst_cnt = 1`.
- **In AUX_BURST:**
  - Each `aux_gnt` increments `burst_cnt`.
  - Return to CPU_PRI at the end of any cycle where `aux_lock = 0`, or `aux_req = 0`, or `burst_cnt == AUX_MAX_BURST` after the increment.
  - On exit, clear `burst_cnt`.
- **Burst limit:**
  - Total locked aux grants per burst never exceed `AUX_MAX_BURST`.
  - After a burst ends on the limit, `wait_cnt` restarts from 0, so the CPU regains priority.
- **Same-address collision:** when both requesters hit the same address, the non-granted access simply waits. There is no merging.

## Timing
- **Reset values** (reset high, sampled at the edge):
  - `cpu_rdata = aux_rdata = 0`.
  - `cpu_rvalid = aux_rvalid = 0`.
  - `wait_cnt = burst_cnt = 0`; state CPU_PRI.
- **Combinational outputs:** the grants and `ram_*` are 0 during reset.
- **Latency:** grant is same-cycle as request; read data is available 1 cycle after the grant cycle.
- **Write timing:** RAM writes occur at the edge that closes the grant cycle.
- **Request hold:** a requester must hold `req`/addr/wdata stable until it sees its `gnt`.
- **Worst-case aux wait:**
  - Under continuous `cpu_req`: `AUX_MAX_WAIT` cycles, with the grant on cycle `AUX_MAX_WAIT+1`.
  - Worst-case CPU stall: `AUX_MAX_BURST` cycles.
- **Reset mid-burst:**
  - Grants drop in the same cycle `reset` goes high.
  - State returns to CPU_PRI at the edge; pending `rvalid` is cleared.
- **Simultaneous events:** a request arriving on the cycle `wait_cnt` saturates is granted per the CPU_PRI equation in that same cycle.

## Test plan
- **Reset:** hold `reset` 2 cycles with both reqs high.
  - Required: `cpu_gnt = aux_gnt = 0`, `ram_en = 0`, all `rdata = 0`, `rvalid = 0`.
- **CPU write then read:**
  - Stimulus: CPU writes 0x5A to 0x20, then reads 0x20, with aux idle.
  - Required: `cpu_gnt` is high both cycles, and the next cycle shows `cpu_rvalid = 1` and `cpu_rdata = 0x5A`.
- **Starvation guard:**
  - Stimulus: `cpu_req` held high; `aux_req` reads 0x0D.
  - Required (AUX_MAX_WAIT=4): `aux_gnt` on the 5th cycle; `cpu_gnt = 0` that cycle; `aux_starved` high that cycle; `wait_cnt` 0 afterwards.
- **Locked burst:**
  - Stimulus: `aux_lock = 1`, 12 consecutive aux writes 0x00..0x0B to addresses 0x40..0x4B, with `cpu_req` high.
  - Required: exactly 8 aux grants, then `cpu_gnt` resumes. RAM holds 0x00..0x07 at 0x40..0x47.
- **Reset mid-burst:**
  - Stimulus: assert `reset` on the 3rd burst cycle.
  - Required: the grant drops that cycle, and after release the CPU is granted first when both reqs are high.
- **Simultaneous requests:**
  - Stimulus: both reqs high, `wait_cnt` 0.
  - Required: `cpu_gnt = 1`, `aux_gnt = 0`, and `ram_addr` equals `cpu_addr`.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Single-port RAM arbiter: CPU has priority, and a starvation counter bounds the aux wait.
// Aux may hold the port for locked bursts of up to AUX_MAX_BURST grants.
module ram_port_arbiter #(
  parameter int unsigned ADDR_W        = 7,
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned AUX_MAX_WAIT  = 4,
  parameter int unsigned AUX_MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic              aux_lock,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_wdata,
  output logic              aux_gnt,
  output logic [DATA_W-1:0] aux_rdata,
  output logic              aux_rvalid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_en,
  input  logic [DATA_W-1:0] ram_q,
  output logic              aux_starved
);

  localparam logic [3:0] LP_MAX_WAIT  = 4'(AUX_MAX_WAIT);
  localparam logic [3:0] LP_MAX_BURST = 4'(AUX_MAX_BURST);

  typedef enum logic {
    CPU_PRI,
    AUX_BURST
  } state_t;

  state_t            r_state;
  logic [3:0]        r_wait_cnt;
  logic [3:0]        r_burst_cnt;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_aux_rdata;
  logic              r_cpu_rvalid;
  logic              r_aux_rvalid;

  logic              w_cpu_gnt;
  logic              w_aux_gnt;
  logic              w_starved;
  logic [3:0]        w_burst_next;

  assign w_starved    = (r_wait_cnt == LP_MAX_WAIT);
  assign w_burst_next = r_burst_cnt + {3'b000, w_aux_gnt};

  always_comb begin
    w_cpu_gnt = 1'b0;
    w_aux_gnt = 1'b0;
    if (!reset) begin
      case (r_state)
        CPU_PRI: begin
          w_aux_gnt = aux_req & (~cpu_req | w_starved);
          w_cpu_gnt = cpu_req & ~w_aux_gnt;
        end
        AUX_BURST: begin
          w_aux_gnt = aux_req;
          w_cpu_gnt = 1'b0;
        end
        default: begin
          w_aux_gnt = 1'b0;
          w_cpu_gnt = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    ram_addr = '0;
    ram_data = '0;
    ram_en   = 1'b0;
    if (w_aux_gnt) begin
      ram_addr = aux_addr;
      ram_data = aux_wdata;
      ram_en   = aux_we;
    end else if (w_cpu_gnt) begin
      ram_addr = cpu_addr;
      ram_data = cpu_wdata;
      ram_en   = cpu_we;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= CPU_PRI;
      r_wait_cnt   <= '0;
      r_burst_cnt  <= '0;
      r_cpu_rdata  <= '0;
      r_aux_rdata  <= '0;
      r_cpu_rvalid <= 1'b0;
      r_aux_rvalid <= 1'b0;
    end else begin
      r_cpu_rvalid <= w_cpu_gnt & ~cpu_we;
      r_aux_rvalid <= w_aux_gnt & ~aux_we;
      if (w_cpu_gnt && !cpu_we) r_cpu_rdata <= ram_q;
      if (w_aux_gnt && !aux_we) r_aux_rdata <= ram_q;

      if (w_aux_gnt || !aux_req) r_wait_cnt <= '0;
      else if (!w_starved)       r_wait_cnt <= r_wait_cnt + 4'd1;

      case (r_state)
        CPU_PRI: begin
          // A limit of one means the entry grant already completes the burst.
          if (w_aux_gnt && aux_lock && (LP_MAX_BURST > 4'd1)) begin
            r_state     <= AUX_BURST;
            r_burst_cnt <= 4'd1;
          end
        end
        AUX_BURST: begin
          if (!aux_lock || !aux_req || (w_burst_next == LP_MAX_BURST)) begin
            r_state     <= CPU_PRI;
            r_burst_cnt <= '0;
          end else begin
            r_burst_cnt <= w_burst_next;
          end
        end
        default: begin
          r_state     <= CPU_PRI;
          r_burst_cnt <= '0;
        end
      endcase
    end
  end

  assign cpu_gnt     = w_cpu_gnt;
  assign aux_gnt     = w_aux_gnt;
  assign cpu_rdata   = r_cpu_rdata;
  assign aux_rdata   = r_aux_rdata;
  assign cpu_rvalid  = r_cpu_rvalid;
  assign aux_rvalid  = r_aux_rvalid;
  assign aux_starved = w_starved;

endmodule
